prio_enc_queue: RTL and testbench
=================================

Name: prio_enc_queue

Overview:
- Parametrised successor to the 8-bit combinational priority encoder.
- Captures request bits into a sticky pending register and serves them one at a time.
- Each served request is presented as an encoded index on a registered valid/ready output, then cleared from pending.
- Sits between interrupt/event sources and a single consumer (sequencer, IRQ controller) that takes one index per handshake.

Parameters:
- WIDTH, 8, number of request lines; legal range 2..64, need not be a power of two.
- IDX_W, $clog2(WIDTH), width of encoded index; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_in  in  WIDTH  request pulses/levels; each set bit is ORed into pending every cycle
- flush  in  1  clears pending and output stage
- out_valid  out  1  out_idx holds a granted request
- out_ready  in  1  consumer accepts out_idx when out_valid&&out_ready
- out_idx  out  IDX_W  encoded index of granted request
- pend  out  WIDTH  current pending register (registered)
- pend_any  out  1  |pend (registered)
- dup  out  1  one-cycle pulse: a req_in bit hit an already-pending, not-granted bit

Behaviour:
- Reset (rst=1 at clock edge): pend=0, out_valid=0, out_idx=0, pend_any=0, dup=0, rr pointer=WIDTH-1. rst overrides flush and all inputs.
- Output slot free: free = !out_valid || out_ready.
- Load: load = free && |pend.
- Select: sel = highest-priority set bit of pend (order below). gmask = onehot(sel) when load, else 0.
- Next state:
  - pend <= (pend & ~gmask) | req_in
  - out_valid <= load || (out_valid && !out_ready)
  - out_idx <= sel on load, else hold
- Stall: while out_valid && !out_ready, out_idx and out_valid are stable. No new grant; pending still accumulates.
- Latency: req_in bit at edge t appears in pend after t. Earliest out_valid with that index is after edge t+1. Back-to-back throughput is one grant per cycle when out_ready is held high.
- Same-cycle re-request: a bit granted and asserted on req_in in the same cycle stays pending, so it is served again later. This is not counted as dup.
- dup <= |(req_in & pend & ~gmask). The duplicate is merged and not queued twice.
- flush=1 (rst=0): pend<=0, out_valid<=0, dup<=0, and req_in that cycle is discarded. out_idx and rr pointer hold.
- pend_any <= |pend_next. pend and pend_any describe the same edge.
- Fixed priority order: index WIDTH-1 highest, descending to 0, matching the 8-bit encoder.
- Unused out_idx codes (WIDTH non-power-of-two) are never produced.

Optional Feature:
- Macro: PRIO_ENC_QUEUE_RR_EN.
- Defined: round-robin priority.
  - Search begins at rr pointer p and descends p, p-1, ..., 0, WIDTH-1, ..., p+1.
  - On each load with index k: p <= (k==0) ? WIDTH-1 : k-1.
  - The pointer is unchanged on stall, idle or flush, and resets to WIDTH-1. Its first grant after reset therefore equals fixed priority.
- Not defined: fixed priority only. No pointer register is synthesised.

Test Plan:
- Basic: reset, out_ready=1, req_in=8'h81 for one cycle. Expect out_valid on 2 consecutive cycles with out_idx=7 then 0. Then out_valid=0 and pend_any=0.
- Stall: pend=8'h0C, out_ready=0 for 5 cycles. Expect out_idx=3 held stable, pend=8'h04. Raise out_ready: expect idx 3 accepted, then idx 2.
- Duplicate/re-request: pend=8'h10 stalled, req_in=8'h10. Expect dup pulse 1 cycle, pend remains 8'h10. With out_ready=1 and grant of bit 4 plus req_in=8'h10 in same cycle: expect no dup, index 4 issued twice.
- Flush/reset mid-operation: pend=8'hFF, out_valid=1, flush with req_in=8'h01. Expect next cycle pend=0, out_valid=0, dup=0. Repeat with rst: expect all outputs at reset values.
- WIDTH=5, fixed: req_in=5'b10110 with out_ready=1. Expect idx sequence 4,2,1 and never 5..7.
- PRIO_ENC_QUEUE_RR_EN, WIDTH=8: hold req_in=8'h88 every cycle, out_ready=1. Expect idx alternating 7,3,7,3. Without the macro, expect 7 every grant.

Source files
------------

// File: rtl/prio_enc_queue.sv
// Sticky-pending priority encoder queue: latches request bits and serves one
// encoded index per valid/ready handshake. Define PRIO_ENC_QUEUE_RR_EN for round-robin priority.
module prio_enc_queue #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pend,
  output logic             pend_any,
  output logic             dup
);

  localparam logic [WIDTH-1:0] ONE_HOT_LSB = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] TOP_IDX     = IDX_W'(WIDTH-1);

  logic [WIDTH-1:0] pend_r;
  logic             pend_any_r;
  logic             dup_r;
  logic             out_valid_r;
  logic [IDX_W-1:0] out_idx_r;

  logic             free_s;
  logic             load_s;
  logic             grant_s;
  logic [IDX_W-1:0] sel_s;
  logic [WIDTH-1:0] gmask_s;
  logic [WIDTH-1:0] pend_next_s;
  logic             dup_next_s;
  logic             valid_next_s;

`ifdef PRIO_ENC_QUEUE_RR_EN
  logic [IDX_W-1:0] rr_ptr_r;

  // Round-robin search: candidate at offset 0 (the pointer) wins, then descending with wrap
  always_comb begin : rr_search
    int cand;
    sel_s = {IDX_W{1'b0}};
    cand  = 0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      cand  = (int'(rr_ptr_r) >= j) ? (int'(rr_ptr_r) - j) : (int'(rr_ptr_r) - j + WIDTH);
      sel_s = pend_r[IDX_W'(cand)] ? IDX_W'(cand) : sel_s;
    end
  end

  // Pointer moves just below each index actually handed to the output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= TOP_IDX;
    end else if (grant_s) begin
      rr_ptr_r <= (sel_s == {IDX_W{1'b0}}) ? TOP_IDX : (sel_s - IDX_W'(1));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority: ascending scan so the highest set index is the last to win
  always_comb begin
    sel_s = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      sel_s = pend_r[i] ? IDX_W'(i) : sel_s;
    end
  end
`endif

  // Handshake, grant mask and next-state terms
  always_comb begin
    free_s  = !out_valid_r || out_ready;
    load_s  = free_s && (|pend_r);
    grant_s = load_s && !flush;
    if (load_s) begin
      gmask_s = ONE_HOT_LSB << sel_s;
    end else begin
      gmask_s = {WIDTH{1'b0}};
    end
    if (flush) begin
      pend_next_s  = {WIDTH{1'b0}};
      dup_next_s   = 1'b0;
      valid_next_s = 1'b0;
    end else begin
      // A bit granted this cycle and re-requested stays pending without counting as dup
      pend_next_s  = (pend_r & ~gmask_s) | req_in;
      dup_next_s   = |(req_in & pend_r & ~gmask_s);
      valid_next_s = load_s || (out_valid_r && !out_ready);
    end
  end

  // State registers; reset dominates flush and every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r      <= {WIDTH{1'b0}};
      pend_any_r  <= 1'b0;
      dup_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
    end else begin
      pend_r      <= pend_next_s;
      pend_any_r  <= |pend_next_s;
      dup_r       <= dup_next_s;
      out_valid_r <= valid_next_s;
      out_idx_r   <= grant_s ? sel_s : out_idx_r;
    end
  end

  assign pend      = pend_r;
  assign pend_any  = pend_any_r;
  assign dup       = dup_r;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Scoreboard bench for prio_enc_queue: an 8-wide and a 5-wide instance,
// directed stimulus, expected grant indices queued and popped by monitors.
module tb_prio_enc_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush8, rdy8, out_valid8, pend_any8, dup8;
  logic [7:0] req8, pend8;
  logic [2:0] idx8;
  logic       flush5, rdy5, out_valid5, pend_any5, dup5;
  logic [4:0] req5, pend5;
  logic [2:0] idx5;

  int checks   = 0;
  int failures = 0;
  int q8[$];
  int q5[$];

  prio_enc_queue #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .req_in(req8), .flush(flush8),
    .out_valid(out_valid8), .out_ready(rdy8), .out_idx(idx8),
    .pend(pend8), .pend_any(pend_any8), .dup(dup8)
  );

  prio_enc_queue #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .req_in(req5), .flush(flush5),
    .out_valid(out_valid5), .out_ready(rdy5), .out_idx(idx5),
    .pend(pend5), .pend_any(pend_any5), .dup(dup5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain8();
    int k = 0;
    while (q8.size() != 0 && k < 30) begin
      tick();
      k++;
    end
    chk("drain8_left", 64'(q8.size()), 64'd0);
  endtask

  task automatic drain5();
    int k = 0;
    while (q5.size() != 0 && k < 30) begin
      tick();
      k++;
    end
    chk("drain5_left", 64'(q5.size()), 64'd0);
  endtask

  // Monitor for the 8-wide instance: every accepted index must match the next expected one
  always @(negedge clk) begin
    if (!rst && out_valid8 && rdy8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant8_extra actual=%0d expected=none", idx8);
      end else begin
        chk("grant8_idx", 64'(idx8), 64'(q8.pop_front()));
      end
    end
  end

  // Monitor for the 5-wide instance, including the legal index range
  always @(negedge clk) begin
    if (!rst && out_valid5) begin
      chk("idx5_range", 64'(idx5 < 3'd5), 64'd1);
      if (rdy5) begin
        if (q5.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL grant5_extra actual=%0d expected=none", idx5);
        end else begin
          chk("grant5_idx", 64'(idx5), 64'(q5.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush8 = 1'b0; rdy8 = 1'b0; req8 = 8'h00;
    flush5 = 1'b0; rdy5 = 1'b0; req5 = 5'h00;
    tick(2);
    chk("rst_valid8", 64'(out_valid8), 64'd0);
    chk("rst_idx8", 64'(idx8), 64'd0);
    chk("rst_pend8", 64'(pend8), 64'd0);
    chk("rst_pend_any8", 64'(pend_any8), 64'd0);
    chk("rst_dup8", 64'(dup8), 64'd0);
    chk("rst_valid5", 64'(out_valid5), 64'd0);
    chk("rst_pend5", 64'(pend5), 64'd0);
    rst = 1'b0;

    // Basic: 8'h81 pulse, grants 7 then 0
    rdy8 = 1'b1; req8 = 8'h81;
    q8.push_back(7); q8.push_back(0);
    tick();
    chk("basic_pend", 64'(pend8), 64'h81);
    chk("basic_pend_any", 64'(pend_any8), 64'd1);
    chk("basic_valid_lat", 64'(out_valid8), 64'd0);
    req8 = 8'h00;
    tick();
    chk("basic_idx7", 64'(idx8), 64'd7);
    chk("basic_valid", 64'(out_valid8), 64'd1);
    chk("basic_pend2", 64'(pend8), 64'h01);
    tick();
    chk("basic_idx0", 64'(idx8), 64'd0);
    chk("basic_pend_any0", 64'(pend_any8), 64'd0);
    tick();
    chk("basic_idle", 64'(out_valid8), 64'd0);
    drain8();

    // Stall: 8'h0C with consumer not ready
    rdy8 = 1'b0; req8 = 8'h0C;
    tick();
    req8 = 8'h00;
    tick();
    chk("stall_idx", 64'(idx8), 64'd3);
    chk("stall_pend", 64'(pend8), 64'h04);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_idx", 64'(idx8), 64'd3);
      chk("stall_hold_valid", 64'(out_valid8), 64'd1);
      chk("stall_hold_pend", 64'(pend8), 64'h04);
    end
    q8.push_back(3); q8.push_back(2);
    rdy8 = 1'b1;
    tick();
    chk("stall_next_idx", 64'(idx8), 64'd2);
    chk("stall_next_pend", 64'(pend8), 64'h00);
    tick();
    chk("stall_idle", 64'(out_valid8), 64'd0);
    drain8();

    // Duplicate while stalled, then same-cycle re-request of the granted bit
    rdy8 = 1'b0; req8 = 8'h30;
    tick();
    req8 = 8'h00;
    tick();
    chk("dup_setup_idx", 64'(idx8), 64'd5);
    chk("dup_setup_pend", 64'(pend8), 64'h10);
    chk("dup_setup_dup", 64'(dup8), 64'd0);
    req8 = 8'h10;
    tick();
    chk("dup_pulse", 64'(dup8), 64'd1);
    chk("dup_pend", 64'(pend8), 64'h10);
    req8 = 8'h00;
    tick();
    chk("dup_clear", 64'(dup8), 64'd0);
    chk("dup_pend_hold", 64'(pend8), 64'h10);
    q8.push_back(5); q8.push_back(4); q8.push_back(4);
    rdy8 = 1'b1; req8 = 8'h10;
    tick();
    chk("rereq_nodup", 64'(dup8), 64'd0);
    chk("rereq_pend", 64'(pend8), 64'h10);
    chk("rereq_idx", 64'(idx8), 64'd4);
    req8 = 8'h00;
    tick();
    chk("rereq_idx2", 64'(idx8), 64'd4);
    chk("rereq_pend0", 64'(pend8), 64'h00);
    tick();
    chk("rereq_idle", 64'(out_valid8), 64'd0);
    drain8();

    // Flush mid-operation
    rdy8 = 1'b0; req8 = 8'hFF;
    tick(2);
    chk("flush_setup_pend", 64'(pend8), 64'hFF);
    chk("flush_setup_valid", 64'(out_valid8), 64'd1);
    flush8 = 1'b1; req8 = 8'h01;
    tick();
    chk("flush_pend", 64'(pend8), 64'h00);
    chk("flush_valid", 64'(out_valid8), 64'd0);
    chk("flush_dup", 64'(dup8), 64'd0);
    chk("flush_pend_any", 64'(pend_any8), 64'd0);
    chk("flush_idx_hold", 64'(idx8), 64'd7);
    flush8 = 1'b0; req8 = 8'h00;
    tick();
    chk("flush_after", 64'(out_valid8), 64'd0);

    // Reset mid-operation
    req8 = 8'hFF;
    tick(2);
    chk("rst_setup_valid", 64'(out_valid8), 64'd1);
    rst = 1'b1; flush8 = 1'b1; req8 = 8'h01;
    tick();
    chk("rst2_valid", 64'(out_valid8), 64'd0);
    chk("rst2_idx", 64'(idx8), 64'd0);
    chk("rst2_pend", 64'(pend8), 64'h00);
    chk("rst2_pend_any", 64'(pend_any8), 64'd0);
    chk("rst2_dup", 64'(dup8), 64'd0);
    rst = 1'b0; flush8 = 1'b0; req8 = 8'h00;
    tick();

    // Held 8'h88: fixed alternates never, round-robin alternates 7/3
    rdy8 = 1'b1; req8 = 8'h88;
`ifdef PRIO_ENC_QUEUE_RR_EN
    q8.push_back(7); q8.push_back(3); q8.push_back(7);
    q8.push_back(3); q8.push_back(7); q8.push_back(3);
`else
    q8.push_back(7); q8.push_back(7); q8.push_back(7);
    q8.push_back(7); q8.push_back(7); q8.push_back(3);
`endif
    tick(5);
    req8 = 8'h00;
    tick(3);
    chk("hold88_idle", 64'(out_valid8), 64'd0);
    chk("hold88_pend", 64'(pend8), 64'h00);
    drain8();

    // WIDTH=5: 5'b10110 served as 4, 2, 1
    rdy5 = 1'b1; req5 = 5'b10110;
    q5.push_back(4); q5.push_back(2); q5.push_back(1);
    tick();
    chk("w5_pend", 64'(pend5), 64'h16);
    req5 = 5'h00;
    tick(4);
    drain5();
    chk("w5_idle", 64'(out_valid5), 64'd0);
    chk("w5_pend_any", 64'(pend_any5), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
